// File: rtl/h264_bs_packer.sv
// Bitstream packer: appends variable-length entropy codes MSB-first into 32-bit words
// held in a 64-entry buffer that the bus side reads by index.
module h264_bs_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        buf_clear,
   input  logic        code_valid,
   input  logic [31:0] code_bits,
   input  logic [5:0]  code_len,
   output logic        code_ready,
   input  logic        flush,
   output logic        flush_done,
   input  logic [5:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic [31:0] buf_cnt,
   output logic        full
);

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] mem [64];
   logic [31:0] pend_q, pend_d;
   logic [4:0]  pcnt_q, pcnt_d;
   logic [6:0]  cnt_q, cnt_d;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [5:0]  len_eff;
   logic [5:0]  total;
   logic [31:0] code_masked;
   logic [6:0]  shamt;
   logic [63:0] merged;
   logic        is_full;
   logic        accept;

   assign is_full    = (cnt_q == 7'd64);
   assign full       = is_full;
   assign buf_cnt    = {25'd0, cnt_q};
   assign code_ready = (state_q == RUN) && !is_full && !flush && !buf_clear;
   assign accept     = code_valid && code_ready;
   assign flush_done = (state_q == DONE) && !buf_clear;
   assign rd_data    = ({1'b0, rd_addr} < cnt_q) ? mem[rd_addr] : 32'h0;

   // Place the new code directly below the pending bits in a 64-bit window;
   // the upper half is the next complete word, the lower half the new remainder.
   always_comb begin
      len_eff     = (code_len > 6'd32) ? 6'd32 : code_len;
      code_masked = (len_eff == 6'd0) ? 32'h0
                                      : (code_bits & (32'hFFFF_FFFF >> (6'd32 - len_eff)));
      total       = {1'b0, pcnt_q} + len_eff;
      shamt       = 7'd64 - {1'b0, total};
      merged      = {pend_q, 32'h0} | ({32'h0, code_masked} << shamt);
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      pcnt_d  = pcnt_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_data = merged[63:32];
      if (buf_clear) begin
         state_d = RUN;
         pend_d  = 32'h0;
         pcnt_d  = 5'd0;
         cnt_d   = 7'd0;
      end else begin
         case (state_q)
            RUN: begin
               if (flush) begin
                  state_d = FLUSH;
               end else if (accept) begin
                  // total < 64, so total - 32 is simply its low five bits
                  pcnt_d = total[4:0];
                  if (total >= 6'd32) begin
                     wr_en  = 1'b1;
                     pend_d = merged[31:0];
                     cnt_d  = cnt_q + 7'd1;
                  end else begin
                     pend_d = merged[63:32];
                  end
               end
            end
            FLUSH: begin
               if (pcnt_q == 5'd0) begin
                  state_d = DONE;
               end else if (!is_full) begin
                  wr_en   = 1'b1;
                  wr_data = pend_q;
                  pend_d  = 32'h0;
                  pcnt_d  = 5'd0;
                  cnt_d   = cnt_q + 7'd1;
                  state_d = DONE;
               end
            end
            DONE: state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pend_q  <= 32'h0;
         pcnt_q  <= 5'd0;
         cnt_q   <= 7'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         pcnt_q  <= pcnt_d;
         cnt_q   <= cnt_d;
      end
   end

   // Word storage carries no reset; the count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[cnt_q[5:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_h264_bs_packer.sv
// Self-checking bench for h264_bs_packer: directed scenarios plus random codes
// compared against a bit-queue reference model.
`timescale 1ns/100ps
module tb_h264_bs_packer;

   logic        clk;
   logic        rst;
   logic        buf_clear;
   logic        code_valid;
   logic [31:0] code_bits;
   logic [5:0]  code_len;
   logic        code_ready;
   logic        flush;
   logic        flush_done;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] buf_cnt;
   logic        full;

   int checks;
   int errors;

   bit          mq[$];
   logic [31:0] mw[64];
   int          mcnt;

   h264_bs_packer dut (
      .clk(clk), .rst(rst), .buf_clear(buf_clear), .code_valid(code_valid),
      .code_bits(code_bits), .code_len(code_len), .code_ready(code_ready),
      .flush(flush), .flush_done(flush_done), .rd_addr(rd_addr), .rd_data(rd_data),
      .buf_cnt(buf_cnt), .full(full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_push(input logic [31:0] b, input int l);
      int n;
      logic [31:0] w;
      n = (l > 32) ? 32 : l;
      for (int i = n - 1; i >= 0; i--) mq.push_back(b[i]);
      while (mq.size() >= 32) begin
         for (int j = 31; j >= 0; j--) w[j] = mq.pop_front();
         mw[mcnt] = w;
         mcnt++;
      end
   endtask

   task automatic m_flush();
      logic [31:0] w;
      if (mq.size() > 0 && mcnt < 64) begin
         while (mq.size() < 32) mq.push_back(1'b0);
         for (int j = 31; j >= 0; j--) w[j] = mq.pop_front();
         mw[mcnt] = w;
         mcnt++;
      end
   endtask

   task automatic m_clear();
      mq.delete();
      mcnt = 0;
   endtask

   task automatic applyStimulus(input logic [31:0] b, input logic [5:0] l);
      int k;
      code_valid = 1'b1;
      code_bits  = b;
      code_len   = l;
      #1;
      k = 0;
      while (!code_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("ready_timeout", (k < 200) ? 1 : 0, 1);
      @(posedge clk);
      m_push(b, int'(l));
      #1;
      code_valid = 1'b0;
   endtask

   task automatic do_clear();
      buf_clear = 1'b1;
      @(posedge clk);
      m_clear();
      #1;
      buf_clear = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_done_c1", flush_done, 0);
      @(posedge clk);
      m_flush();
      #1;
      chk("flush_done_c2", flush_done, 1);
      @(posedge clk); #1;
      chk("flush_done_c3", flush_done, 0);
      chk("flush_buf_cnt", buf_cnt, mcnt);
   endtask

   task automatic checkOutput(input string tag);
      chk({tag, "_buf_cnt"}, buf_cnt, mcnt);
      chk({tag, "_full"}, full, (mcnt == 64) ? 1 : 0);
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a);
         #1;
         chk($sformatf("%s_rd%0d", tag, a), rd_data, (a < mcnt) ? mw[a] : 32'h0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      mcnt       = 0;
      rst        = 1'b1;
      buf_clear  = 1'b0;
      code_valid = 1'b0;
      code_bits  = 32'h0;
      code_len   = 6'd0;
      flush      = 1'b0;
      rd_addr    = 6'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_buf_cnt", buf_cnt, 0);
      chk("rst_full", full, 0);
      chk("rst_code_ready", code_ready, 1);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_rd_data", rd_data, 0);

      // Three codes that exactly fill one word, then an empty flush
      applyStimulus(32'h5, 6'd3);
      applyStimulus(32'h3, 6'd5);
      applyStimulus(32'hABCDEF, 6'd24);
      rd_addr = 6'd0;
      #1;
      chk("pack_word0", rd_data, 32'hA3ABCDEF);
      chk("pack_buf_cnt", buf_cnt, 1);
      do_flush();
      chk("empty_flush_cnt", buf_cnt, 1);
      checkOutput("pack");

      // Reset mid-code discards pending bits and stored words
      applyStimulus(32'hF, 6'd4);
      rst = 1'b1;
      @(posedge clk);
      m_clear();
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_buf_cnt", buf_cnt, 0);
      do_flush();
      chk("midrst_no_word", buf_cnt, 0);

      // Single short code padded by flush
      applyStimulus(32'hF, 6'd4);
      do_flush();
      rd_addr = 6'd0;
      #1;
      chk("flush_word0", rd_data, 32'hF0000000);
      chk("flush_cnt", buf_cnt, 1);

      // Read window with three words
      do_clear();
      applyStimulus(32'h12345678, 6'd32);
      applyStimulus(32'h9ABCDEF0, 6'd32);
      applyStimulus(32'h0F1E2D3C, 6'd40);
      rd_addr = 6'd2;
      #1;
      chk("win_rd2", rd_data, 32'h0F1E2D3C);
      rd_addr = 6'd3;
      #1;
      chk("win_rd3", rd_data, 32'h0);
      checkOutput("win");

      // Clear collides with code_valid and flush
      buf_clear  = 1'b1;
      code_valid = 1'b1;
      code_bits  = 32'hDEADBEEF;
      code_len   = 6'd32;
      flush      = 1'b1;
      #1;
      chk("coll_code_ready", code_ready, 0);
      @(posedge clk);
      m_clear();
      #1;
      buf_clear  = 1'b0;
      code_valid = 1'b0;
      flush      = 1'b0;
      #1;
      chk("coll_buf_cnt", buf_cnt, 0);
      chk("coll_flush_done_a", flush_done, 0);
      @(posedge clk); #1;
      chk("coll_flush_done_b", flush_done, 0);
      chk("coll_buf_cnt_b", buf_cnt, 0);

      // Fill to 64 words, hold the 65th code until a clear
      for (int i = 0; i < 64; i++) applyStimulus(32'hFFFF_FFFF, 6'd32);
      chk("full_flag", full, 1);
      chk("full_ready", code_ready, 0);
      chk("full_cnt", buf_cnt, 64);
      code_valid = 1'b1;
      code_bits  = 32'hFFFF_FFFF;
      code_len   = 6'd32;
      repeat (3) begin
         @(posedge clk); #1;
         chk("held_ready", code_ready, 0);
         chk("held_cnt", buf_cnt, 64);
      end
      buf_clear = 1'b1;
      #1;
      chk("clear_ready", code_ready, 0);
      @(posedge clk);
      m_clear();
      #1;
      buf_clear = 1'b0;
      #1;
      chk("after_clear_cnt", buf_cnt, 0);
      chk("after_clear_ready", code_ready, 1);
      @(posedge clk);
      m_push(32'hFFFF_FFFF, 32);
      #1;
      code_valid = 1'b0;
      chk("held_accepted_cnt", buf_cnt, 1);
      checkOutput("held");

      // Flush while full with pending bits stays stuck until a clear
      do_clear();
      applyStimulus(32'h7, 6'd3);
      for (int i = 0; i < 64; i++) applyStimulus($urandom, 6'd32);
      chk("stuck_full", full, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("stuck_flush_done", flush_done, 0);
         chk("stuck_cnt", buf_cnt, 64);
      end
      buf_clear = 1'b1;
      #1;
      chk("stuck_clear_fd", flush_done, 0);
      @(posedge clk);
      m_clear();
      #1;
      buf_clear = 1'b0;
      #1;
      chk("stuck_cleared_cnt", buf_cnt, 0);
      do_flush();

      // Random codes, lengths beyond 32 included, with interleaved flushes
      for (int r = 0; r < 4; r++) begin
         do_clear();
         for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) do_flush();
            else applyStimulus($urandom, 6'($urandom_range(0, 40)));
         end
         do_flush();
         checkOutput($sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/h264_bs_packer.md
H264_BS_PACKER -- requirements
Module: h264_bs_packer

Interface
REQ-001 The module SHALL use the clock and reset: clk, rst; reset rst, synchronous, active-high; clock clk.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- buf_clear  in  1  level; empties word buffer and bit accumulator
- code_valid  in  1  entropy coder presents a code
- code_bits  in  32  code value, right-aligned (LSB = last bit emitted)
- code_len  in  6  code length in bits, 0..32
- code_ready  out  1  packer accepts the code this cycle
- flush  in  1  pulse; pad pending bits to a word boundary
- flush_done  out  1  one-cycle pulse when the flush completes
- rd_addr  in  6  word read index, driven by the bus-side read counter
- rd_data  out  32  packed word at rd_addr
- buf_cnt  out  32  number of valid packed words (0..64)
- full  out  1  buf_cnt == 64

Function
REQ-003 The module SHALL hold a 64x32 word buffer, a 32-bit pending-bit register pend and a pending count pcnt (0..31).
REQ-004 A code SHALL be accepted on code_valid && code_ready. Its low code_len bits SHALL be appended MSB-first after the pend bits.
REQ-005 On acceptance, if pcnt+code_len >= 32:
- the first 32 bits SHALL be written to buffer[buf_cnt] in the same clock edge;
- buf_cnt SHALL increment;
- the remainder SHALL stay in pend with pcnt = pcnt+code_len-32.
Otherwise pcnt SHALL increase by code_len and no word is written.
REQ-006 code_len == 0 SHALL be accepted as a no-op. code_len > 32 SHALL be treated as 32.
REQ-007 A packed word SHALL carry its first bit in bit 31. New bits in pend SHALL be left-justified.
REQ-008 The state machine SHALL have three states: RUN, FLUSH, DONE.
REQ-009 code_ready SHALL be 1 only in RUN with full == 0.
REQ-010 RUN -> FLUSH SHALL occur on flush == 1. Flush takes priority, so a code_valid presented in the same cycle is not accepted.
REQ-011 In FLUSH with pcnt > 0 and full == 0:
- pend SHALL be written zero-padded in its low bits to buffer[buf_cnt];
- buf_cnt SHALL increment and pcnt SHALL become 0;
- the state SHALL go to DONE.
REQ-012 In FLUSH with pcnt == 0, the state SHALL go to DONE without writing a word.
REQ-013 In FLUSH with full == 1 and pcnt > 0, the state SHALL remain in FLUSH until buf_clear.
REQ-014 DONE SHALL assert flush_done for exactly one cycle, then return to RUN.
REQ-015 buf_clear SHALL have priority over all other inputs. It SHALL set buf_cnt = 0, pcnt = 0, pend = 0 and state = RUN, and SHALL suppress acceptance and flush_done in that cycle. Buffer contents need not be zeroed.
REQ-016 rd_data SHALL be combinational: buffer[rd_addr] when rd_addr < buf_cnt, else 32'h0.
REQ-017 A word written at edge N SHALL be readable, and counted in buf_cnt, from cycle N+1.
REQ-018 While full == 1 in RUN, pend and pcnt SHALL be held and no code SHALL be accepted. An accepted code never overflows the buffer.
REQ-019 buf_cnt SHALL saturate at 64 and SHALL never wrap.

Reset
REQ-020 On rst, the module SHALL set state = RUN, buf_cnt = 0, pcnt = 0, pend = 0, code_ready = 1, flush_done = 0, full = 0, rd_data = 0.
REQ-021 rst asserted mid-flush or mid-code SHALL discard all pending bits and stored words.
REQ-022 No buffer-memory reset SHALL be required.

Verification
REQ-023 Pack: codes (3'b101,3), (5'b00011,5), (24'hABCDEF,24) -> buf_cnt = 1, buffer[0] = 32'hA3ABCDEF, pcnt = 0.
REQ-024 Flush: code (4'hF,4) then flush pulse -> buffer[0] = 32'hF0000000, buf_cnt = 1, flush_done pulses 2 cycles after flush.
REQ-025 Empty flush: flush with pcnt = 0 -> no write, buf_cnt unchanged, flush_done pulses once.
REQ-026 Full: 64 codes of (32'hFFFF_FFFF,32) -> full = 1, code_ready = 0; the 65th code is held until buf_clear, after which buf_cnt = 0 and the code is accepted.
REQ-027 Clear collision: buf_clear with code_valid and flush in the same cycle -> code not accepted, no flush_done, buf_cnt = 0.
REQ-028 Read window: after 3 words, rd_addr = 0..2 returns the packed words and rd_addr = 3 returns 32'h0.
